// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline-stage register:
// state encoding, "no exception" code and default widths.
package pipe_pkg;

   localparam int DATA_W_DEF = 128;
   localparam int PC_W_DEF   = 32;
   localparam int EXC_W_DEF  = 5;

   // Exception code value meaning "no exception".
   localparam int EXC_NONE   = 0;

   // State value equals the number of held entries, so it drives occ directly.
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } state_e;

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Handshake bus around one pipeline-stage register.
// master = upstream/downstream environment, slave = the stage itself.
interface pipe_stage_reg_if #(
   parameter int DATA_W = pipe_pkg::DATA_W_DEF,
   parameter int PC_W   = pipe_pkg::PC_W_DEF,
   parameter int EXC_W  = pipe_pkg::EXC_W_DEF
) ();

   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic [PC_W-1:0]   in_pc;
   logic              in_bd;
   logic [EXC_W-1:0]  in_exc;
   logic              flush;
   logic [PC_W-1:0]   flush_pc;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic [PC_W-1:0]   out_pc;
   logic              out_bd;
   logic [EXC_W-1:0]  out_exc;
   logic [1:0]        occ;

   modport master (
      output in_valid, in_data, in_pc, in_bd, in_exc, flush, flush_pc, out_ready,
      input  in_ready, out_valid, out_data, out_pc, out_bd, out_exc, occ
   );

   modport slave (
      input  in_valid, in_data, in_pc, in_bd, in_exc, flush, flush_pc, out_ready,
      output in_ready, out_valid, out_data, out_pc, out_bd, out_exc, occ
   );

endinterface

// File: rtl/pipe_entry.sv
// One storage slot of the stage register (payload, PC, BD, exception).
// Clear wins over load; clear zeroes everything except the PC, which
// takes the preset value so the emptied slot still reports a defined PC.
module pipe_entry
   import pipe_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int PC_W   = PC_W_DEF,
   parameter int EXC_W  = EXC_W_DEF
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              load_i,
   input  logic              clr_i,
   input  logic [PC_W-1:0]   clr_pc_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic [PC_W-1:0]   pc_i,
   input  logic              bd_i,
   input  logic [EXC_W-1:0]  exc_i,
   output logic [DATA_W-1:0] data_o,
   output logic [PC_W-1:0]   pc_o,
   output logic              bd_o,
   output logic [EXC_W-1:0]  exc_o
);

   logic [DATA_W-1:0] data_q;
   logic [PC_W-1:0]   pc_q;
   logic              bd_q;
   logic [EXC_W-1:0]  exc_q;

   // Slot contents: reset to zero, clear with PC preset, or load a beat.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         data_q <= '0;
         pc_q   <= '0;
         bd_q   <= 1'b0;
         exc_q  <= EXC_W'(EXC_NONE);
      end else if (clr_i) begin
         data_q <= '0;
         pc_q   <= clr_pc_i;
         bd_q   <= 1'b0;
         exc_q  <= EXC_W'(EXC_NONE);
      end else if (load_i) begin
         data_q <= data_i;
         pc_q   <= pc_i;
         bd_q   <= bd_i;
         exc_q  <= exc_i;
      end
   end

   assign data_o = data_q;
   assign pc_o   = pc_q;
   assign bd_o   = bd_q;
   assign exc_o  = exc_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline-stage register with valid/ready handshake and
// exception-aware flush. Define PIPE_SKID_EN to build the second (skid)
// entry; in_ready then depends on state only. Without it a single head
// entry is built and in_ready passes out_ready through combinationally.
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int PC_W   = PC_W_DEF,
   parameter int EXC_W  = EXC_W_DEF
) (
   input  logic             clk,
   input  logic             reset_n,
   pipe_stage_reg_if.slave  bus
);

   state_e            state_q;
   logic              acc;
   logic              dlv;
   logic              h_load;
   logic [DATA_W-1:0] h_data_d;
   logic [PC_W-1:0]   h_pc_d;
   logic              h_bd_d;
   logic [EXC_W-1:0]  h_exc_d;

   assign bus.out_valid = (state_q != ST_EMPTY);
`ifdef PIPE_SKID_EN
   assign bus.in_ready  = (state_q != ST_FULL);
`else
   assign bus.in_ready  = !bus.out_valid || bus.out_ready;
`endif
   assign acc     = bus.in_valid && bus.in_ready;
   assign dlv     = bus.out_valid && bus.out_ready;
   assign bus.occ = state_q;

`ifdef PIPE_SKID_EN
   logic              h_from_s;
   logic              s_load;
   logic              s_clr;
   logic [DATA_W-1:0] s_data;
   logic [PC_W-1:0]   s_pc;
   logic              s_bd;
   logic [EXC_W-1:0]  s_exc;

   // Entry steering: head takes the new beat or the skid entry; skid
   // absorbs one beat when the head is stalled.
   always_comb begin
      h_load   = 1'b0;
      h_from_s = 1'b0;
      s_load   = 1'b0;
      s_clr    = 1'b0;
      case (state_q)
         ST_EMPTY: h_load = acc;
         ST_ONE: begin
            if (acc && dlv) h_load = 1'b1;
            else if (acc)   s_load = 1'b1;
         end
         ST_FULL: begin
            if (dlv) begin
               h_load   = 1'b1;
               h_from_s = 1'b1;
               s_clr    = 1'b1;
            end
         end
         default: ;
      endcase
   end

   assign h_data_d = h_from_s ? s_data : bus.in_data;
   assign h_pc_d   = h_from_s ? s_pc   : bus.in_pc;
   assign h_bd_d   = h_from_s ? s_bd   : bus.in_bd;
   assign h_exc_d  = h_from_s ? s_exc  : bus.in_exc;

   pipe_entry #(.DATA_W(DATA_W), .PC_W(PC_W), .EXC_W(EXC_W)) u_skid (
      .clk      (clk),
      .reset_n  (reset_n),
      .load_i   (s_load),
      .clr_i    (bus.flush || s_clr),
      .clr_pc_i (bus.flush ? bus.flush_pc : '0),
      .data_i   (bus.in_data),
      .pc_i     (bus.in_pc),
      .bd_i     (bus.in_bd),
      .exc_i    (bus.in_exc),
      .data_o   (s_data),
      .pc_o     (s_pc),
      .bd_o     (s_bd),
      .exc_o    (s_exc)
   );
`else
   // Single entry: head loads whenever a beat is accepted.
   always_comb begin
      h_load = acc;
   end

   assign h_data_d = bus.in_data;
   assign h_pc_d   = bus.in_pc;
   assign h_bd_d   = bus.in_bd;
   assign h_exc_d  = bus.in_exc;
`endif

   // Occupancy FSM; flush overrides any handshake in the same cycle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_EMPTY;
      end else if (bus.flush) begin
         state_q <= ST_EMPTY;
      end else begin
         case (state_q)
            ST_EMPTY: if (acc) state_q <= ST_ONE;
            ST_ONE: begin
`ifdef PIPE_SKID_EN
               if (acc && !dlv) state_q <= ST_FULL;
`endif
               if (!acc && dlv) state_q <= ST_EMPTY;
            end
`ifdef PIPE_SKID_EN
            ST_FULL: if (dlv) state_q <= ST_ONE;
`endif
            default: state_q <= ST_EMPTY;
         endcase
      end
   end

   pipe_entry #(.DATA_W(DATA_W), .PC_W(PC_W), .EXC_W(EXC_W)) u_head (
      .clk      (clk),
      .reset_n  (reset_n),
      .load_i   (h_load),
      .clr_i    (bus.flush),
      .clr_pc_i (bus.flush_pc),
      .data_i   (h_data_d),
      .pc_i     (h_pc_d),
      .bd_i     (h_bd_d),
      .exc_i    (h_exc_d),
      .data_o   (bus.out_data),
      .pc_o     (bus.out_pc),
      .bd_o     (bus.out_bd),
      .exc_o    (bus.out_exc)
   );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: table of per-cycle vectors plus
// a hand-written asynchronous reset sequence. Skid-specific vectors are
// built only when PIPE_SKID_EN is defined.
module tb_pipe_stage_reg;

   logic clk;
   logic reset_n;
   int   n_chk  = 0;
   int   n_fail = 0;

   pipe_stage_reg_if #(.DATA_W(128), .PC_W(32), .EXC_W(5)) bus ();

   pipe_stage_reg #(.DATA_W(128), .PC_W(32), .EXC_W(5)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic         iv;
      logic [127:0] id;
      logic [31:0]  ipc;
      logic         ibd;
      logic [4:0]   iexc;
      logic         ordy;
      logic         fl;
      logic [31:0]  fpc;
      logic         e_irdy;
      logic         e_ov;
      logic [1:0]   e_occ;
      logic         cd;
      logic [127:0] e_od;
      logic         e_bd;
      logic [4:0]   e_exc;
      logic         cp;
      logic [31:0]  e_pc;
   } vec_t;

   vec_t vq[$];

   task automatic add(input logic iv, input logic [127:0] id, input logic [31:0] ipc,
                      input logic ibd, input logic [4:0] iexc, input logic ordy,
                      input logic fl, input logic [31:0] fpc, input logic e_irdy,
                      input logic e_ov, input logic [1:0] e_occ, input logic cd,
                      input logic [127:0] e_od, input logic e_bd, input logic [4:0] e_exc,
                      input logic cp, input logic [31:0] e_pc);
      vec_t v;
      v.iv = iv; v.id = id; v.ipc = ipc; v.ibd = ibd; v.iexc = iexc;
      v.ordy = ordy; v.fl = fl; v.fpc = fpc; v.e_irdy = e_irdy; v.e_ov = e_ov;
      v.e_occ = e_occ; v.cd = cd; v.e_od = e_od; v.e_bd = e_bd; v.e_exc = e_exc;
      v.cp = cp; v.e_pc = e_pc;
      vq.push_back(v);
   endtask

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic iv, input logic [127:0] id, input logic [31:0] ipc,
                        input logic ordy);
      bus.in_valid  = iv;
      bus.in_data   = id;
      bus.in_pc     = ipc;
      bus.in_bd     = 1'b0;
      bus.in_exc    = '0;
      bus.out_ready = ordy;
      bus.flush     = 1'b0;
      bus.flush_pc  = '0;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, " out_valid"}, bus.out_valid, 1'b0);
      chk({tag, " out_data"},  bus.out_data,  '0);
      chk({tag, " out_pc"},    bus.out_pc,    '0);
      chk({tag, " out_bd"},    bus.out_bd,    1'b0);
      chk({tag, " out_exc"},   bus.out_exc,   '0);
      chk({tag, " occ"},       bus.occ,       2'd0);
      chk({tag, " in_ready"},  bus.in_ready,  1'b1);
   endtask

   initial begin
      vec_t v;
      reset_n = 1'b0;
      drive(1'b0, '0, '0, 1'b0);

      // ---- vector table ----
      // stream 1..8 with out_ready high: 1-cycle latency, occ stays 1
      for (int i = 1; i <= 8; i++)
         add(1, 128'(i), 32'h100 + 32'(4*i), i[0], i[4:0], 1, 0, 0,
             1, 1, 2'd1, 1, 128'(i), i[0], i[4:0], 1, 32'h100 + 32'(4*i));
      add(0, 0, 0, 0, 0, 1, 0, 0,  1, 0, 2'd0, 0, 0, 0, 0, 0, 0);
`ifdef PIPE_SKID_EN
      // stall: A into H, B into S, C held off; release drains A,B,C in order
      add(1, 'hA, 'h200, 0, 0, 0, 0, 0,  1, 1, 2'd1, 1, 'hA, 0, 0, 1, 'h200);
      add(1, 'hB, 'h204, 1, 3, 0, 0, 0,  1, 1, 2'd2, 1, 'hA, 0, 0, 1, 'h200);
      add(1, 'hC, 'h208, 0, 7, 0, 0, 0,  0, 1, 2'd2, 1, 'hA, 0, 0, 1, 'h200);
      add(1, 'hC, 'h208, 0, 7, 1, 0, 0,  0, 1, 2'd1, 1, 'hB, 1, 3, 1, 'h204);
      add(1, 'hC, 'h208, 0, 7, 1, 0, 0,  1, 1, 2'd1, 1, 'hC, 0, 7, 1, 'h208);
      add(0, 0, 0, 0, 0, 1, 0, 0,  1, 0, 2'd0, 0, 0, 0, 0, 0, 0);
      // refill to FULL ahead of the flush
      add(1, 'hA, 'h200, 0, 0, 0, 0, 0,  1, 1, 2'd1, 1, 'hA, 0, 0, 1, 'h200);
      add(1, 'hB, 'h204, 1, 3, 0, 0, 0,  1, 1, 2'd2, 1, 'hA, 0, 0, 1, 'h200);
`else
      // H stalled blocks B; raising out_ready and in_valid together swaps in B
      add(1, 'hA, 'h200, 0, 0, 0, 0, 0,  1, 1, 2'd1, 1, 'hA, 0, 0, 1, 'h200);
      add(1, 'hB, 'h204, 1, 3, 0, 0, 0,  0, 1, 2'd1, 1, 'hA, 0, 0, 1, 'h200);
      add(1, 'hB, 'h204, 1, 3, 1, 0, 0,  1, 1, 2'd1, 1, 'hB, 1, 3, 1, 'h204);
      add(0, 0, 0, 0, 0, 1, 0, 0,  1, 0, 2'd0, 0, 0, 0, 0, 0, 0);
      // H full and stalled ahead of the flush
      add(1, 'hA, 'h200, 0, 0, 0, 0, 0,  1, 1, 2'd1, 1, 'hA, 0, 0, 1, 'h200);
`endif
      // flush while stalled: empty, zero payload, PC preset
      add(0, 0, 0, 0, 0, 0, 1, 'h4180,  0, 0, 2'd0, 1, 0, 0, 0, 1, 'h4180);
      // flush together with an accept of D (exc 10): D dropped
      add(1, 'hD, 'h300, 1, 10, 1, 1, 'h4180,  1, 0, 2'd0, 1, 0, 0, 0, 1, 'h4180);
      add(0, 0, 0, 0, 0, 1, 0, 0,  1, 0, 2'd0, 1, 0, 0, 0, 1, 'h4180);

      // ---- reset state (asynchronous, checked before any clock edge) ----
      #3;
      chk_zero("reset");
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;

      // ---- apply table ----
      for (int k = 0; k < vq.size(); k++) begin
         v = vq[k];
         bus.in_valid  = v.iv;
         bus.in_data   = v.id;
         bus.in_pc     = v.ipc;
         bus.in_bd     = v.ibd;
         bus.in_exc    = v.iexc;
         bus.out_ready = v.ordy;
         bus.flush     = v.fl;
         bus.flush_pc  = v.fpc;
         #1;
         chk($sformatf("v%0d in_ready", k), bus.in_ready, v.e_irdy);
         @(posedge clk);
         #1;
         chk($sformatf("v%0d out_valid", k), bus.out_valid, v.e_ov);
         chk($sformatf("v%0d occ", k), bus.occ, v.e_occ);
         if (v.cd) begin
            chk($sformatf("v%0d out_data", k), bus.out_data, v.e_od);
            chk($sformatf("v%0d out_bd", k), bus.out_bd, v.e_bd);
            chk($sformatf("v%0d out_exc", k), bus.out_exc, v.e_exc);
         end
         if (v.cp) chk($sformatf("v%0d out_pc", k), bus.out_pc, v.e_pc);
      end

      // ---- asynchronous reset mid-stream with the stage full ----
      drive(1'b1, 'hA, 'h200, 1'b0);
      @(posedge clk); #1;
      drive(1'b1, 'hB, 'h204, 1'b0);
      @(posedge clk); #1;
`ifdef PIPE_SKID_EN
      chk("pre-reset occ", bus.occ, 2'd2);
`else
      chk("pre-reset occ", bus.occ, 2'd1);
`endif
      #2;
      reset_n = 1'b0;
      #1;
      chk_zero("midreset");
      #1;
      reset_n = 1'b1;
      drive(1'b0, '0, '0, 1'b1);
      @(posedge clk); #1;
      drive(1'b1, 'hE, 'h400, 1'b1);
      #1;
      chk("post-reset in_ready", bus.in_ready, 1'b1);
      @(posedge clk); #1;
      chk("post-reset out_valid", bus.out_valid, 1'b1);
      chk("post-reset out_data", bus.out_data, 128'hE);
      chk("post-reset out_pc", bus.out_pc, 32'h400);
      chk("post-reset occ", bus.occ, 2'd1);
      drive(1'b0, '0, '0, 1'b1);
      @(posedge clk); #1;
      chk("post-reset drain", bus.out_valid, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised, elastic pipeline-stage register that replaces the hand-written per-stage registers between pipeline stages (F/D, D/E, E/M, M/W). Unlike a plain enable/clear register, it carries a valid/ready handshake, an optional two-entry skid buffer, and an exception-aware flush that keeps a defined PC in the emptied slot for CP0/EPC logic. Each stage instance sits between two adjacent pipeline stages and carries an opaque control/data payload plus the PC, branch-delay (BD) flag and exception code.

## Interface
- `DATA_W`, default 128: width of the opaque payload bus (control bits, ALU result, store data, and so on).
- `PC_W`, default 32: PC width.
- `EXC_W`, default 5: exception-code width. Zero means no exception.
- `clk` input, 1 bit: single clock. All state is updated on its rising edge.
- `reset_n` input, 1 bit: asynchronous, active-low reset.
- `in_valid` input, 1 bit: upstream beat is valid.
- `in_ready` output, 1 bit: the stage can accept a beat this cycle.
- `in_data` input, `DATA_W` bits: upstream payload.
- `in_pc` input, `PC_W` bits: PC of the upstream instruction.
- `in_bd` input, 1 bit: the upstream instruction is in a branch-delay slot.
- `in_exc` input, `EXC_W` bits: upstream exception code.
- `flush` input, 1 bit: exception/interrupt request. Kills all contents.
- `flush_pc` input, `PC_W` bits: PC loaded into the emptied slot on `flush`.
- `out_valid` output, 1 bit: the head entry is valid.
- `out_ready` input, 1 bit: downstream accepts the head entry.
- `out_data`, `out_pc`, `out_bd`, `out_exc` outputs, widths `DATA_W` / `PC_W` / 1 / `EXC_W`: head entry fields.
- `occ` output, 2 bits: entries held (0–2).

## Operation
- Handshake rules:
  - A beat is accepted when `in_valid && in_ready`.
  - A beat is delivered when `out_valid && out_ready`.
  - Payload is never modified while held.
- Storage:
  - Head register H is always present.
  - Skid register S is present only with the configuration macro defined.
- State machine (macro defined), with states EMPTY (occ=0), ONE (occ=1) and FULL (occ=2):
  - EMPTY, accept → ONE. The beat is written into H.
  - ONE, accept without deliver → FULL. The beat is written into S.
  - ONE, accept and deliver → ONE. H is replaced by the incoming beat.
  - ONE, deliver only → EMPTY.
  - FULL, deliver → ONE. S moves into H and S is cleared.
  - FULL never accepts, because `in_ready` is 0.
- `in_ready` is combinational from state only and equals NOT FULL. It has no combinational path from `out_ready`.
- `flush` has priority over every handshake in the same cycle:
  - Next state is EMPTY.
  - H and S payload, `bd` and `exc` are zeroed.
  - H's PC loads `flush_pc`, and `out_pc` shows `flush_pc` while empty.
  - A beat presented with `flush` is dropped, even though `in_ready` reads 1.
- When empty after a flush, all outputs except `out_pc` read 0.
- Exception codes and BD travel with their beat and are not interpreted here.
- Reset (asynchronous, any time, including mid-transfer):
  - State goes to EMPTY, and `occ`=0.
  - `out_valid`=0, and `out_data`, `out_pc`, `out_bd`, `out_exc` are all 0.
  - `in_ready`=1 while `reset_n` is low and afterwards.

## Timing
- Latency is 1 cycle: a beat accepted at edge N is on the outputs after edge N, with `out_valid`=1.
- Throughput is 1 beat per cycle when `out_ready` is held at 1.
- With the macro defined:
  - After `out_ready` falls, up to 1 further beat is absorbed.
  - `in_ready` falls in the cycle after FULL is entered.
- `flush` takes effect at the next rising edge. Outputs are cleared one cycle after `flush` is sampled.
- `flush` and reset are the only events that drop beats.

## Configuration
- `PIPE_SKID_EN` defined:
  - The two-entry skid buffer and the FSM above are built.
  - `in_ready` is registered-state-only.
- `PIPE_SKID_EN` undefined:
  - Only H is built, and `occ` ∈ {0,1}.
  - `in_ready` = NOT `out_valid` OR `out_ready`, a combinational pass-through.
  - Flush and reset behaviour is identical.

## Structure
- Shared package `pipe_pkg` holds:
  - the state encoding typedef (EMPTY=2'd0, ONE=2'd1, FULL=2'd2);
  - the `EXC_NONE`=0 constant;
  - the default width constants.
- A natural sub-module is `pipe_entry`. It is one storage slot (payload, PC, BD, exc) with load, clear and PC-preset controls, and is instantiated as H and S.

## Test plan
- Reset, then stream 0x1..0x8 with `out_ready`=1 → outputs 0x1..0x8 on consecutive cycles, 1-cycle latency, `occ` never exceeds 1.
- Hold `out_ready`=0 while sending 0xA, 0xB, 0xC → `occ`=2 and `in_ready`=0 after 0xB, 0xC is held off, and on release outputs are 0xA, 0xB, 0xC in order (macro on).
- FULL with 0xA/0xB, then `flush`=1 and `flush_pc`=0x00004180 → next cycle `out_valid`=0, `out_data`=0, `out_pc`=0x00004180, `occ`=0.
- `flush` in the same cycle as an accept of 0xD with `in_exc`=5'd10 → 0xD dropped, `out_exc`=0.
- Deassert `reset_n` mid-stream with `occ`=2 → all outputs 0 and `in_ready`=1 immediately (asynchronous). After release, the first beat sent goes through with 1-cycle latency.
- Macro off, `out_ready`=0 with H full, then raise `out_ready` and `in_valid` together → `in_ready`=1 in the same cycle and the new beat replaces the old one with no gap.
